pwm_to_pcm: RTL and testbench

Recovers 16-bit signed PCM samples from a fixed-period PWM stream, such as the output of our PCM-to-PWM converter. It is used for loopback checking of the audio PWM path and for capturing PWM audio from external sources. The block synchronises the PWM input and locks to the frame start. It counts high cycles per frame and emits one PCM sample per frame with a valid strobe, plus lock and error status.

---
 rtl/pwm_pcm_pkg.sv | 37 +++
 rtl/pwm_sync_edge.sv | 40 ++++
 rtl/pwm_to_pcm.sv | 197 +++++++++++++++++++
 tb/tb_pwm_to_pcm.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pcm_pkg.sv
// pwm_pcm_pkg: shared types, constants and decode helpers for the PWM-to-PCM
// recovery block.
//   PCM_W            sample width
//   PCM_OFFSET       offset-binary to two's-complement flip
//   pwm_dec_state_t  frame tracker states
//   decode_hc        high-cycle count -> signed PCM sample (clamped)
//   avg_pcm          floor mean of two signed samples
package pwm_pcm_pkg;

  localparam int PCM_W = 16;
  localparam logic [PCM_W-1:0] PCM_OFFSET = 16'h8000;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } pwm_dec_state_t;

  // hc is at most 2^period_log2, so the scaled value needs 17 bits; the only
  // value that overflows 16 bits is a full-high frame, which clamps to 0xFFFF.
  function automatic logic [PCM_W-1:0] decode_hc(input logic [16:0] hc,
                                                 input int unsigned period_log2);
    logic [16:0]      u;
    logic [PCM_W-1:0] u_clamped;
    u = hc << (16 - period_log2);
    u_clamped = u[16] ? 16'hFFFF : u[15:0];
    return u_clamped ^ PCM_OFFSET;
  endfunction

  // Sign-extended 17-bit sum; dropping the LSB is an arithmetic shift (floor).
  function automatic logic [PCM_W-1:0] avg_pcm(input logic [PCM_W-1:0] a,
                                               input logic [PCM_W-1:0] b);
    logic [PCM_W:0] sum;
    sum = {a[PCM_W-1], a} + {b[PCM_W-1], b};
    return sum[PCM_W:1];
  endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: multi-flop synchroniser for an asynchronous line plus a
// registered rising-edge detector.
//   clk   in   sampling clock
//   d_in  in   asynchronous input
//   s     out  synchronised level
//   rise  out  high for the one cycle in which s first reads 1
// The chain is deliberately not reset: it flushes itself within STAGES
// clocks, and keeping it free-running lets the frame tracker see the true
// next edge after a reset instead of a fake one from a cleared chain.
module pwm_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic d_in,
  output logic s,
  output logic rise
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              s_q, s_d;
  logic              rise_q, rise_d;

  // s and rise are both registered from the last chain stage so that they
  // stay aligned: rise == s & ~(previous s).
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d_in};
    s_d     = chain_q[STAGES-1];
    rise_d  = chain_q[STAGES-1] & ~s_q;
  end

  always_ff @(posedge clk) begin
    chain_q <= chain_d;
    s_q     <= s_d;
    rise_q  <= rise_d;
  end

  assign s    = s_q;
  assign rise = rise_q;

endmodule

// File: rtl/pwm_to_pcm.sv
// pwm_to_pcm: recovers 16-bit signed PCM samples from a fixed-period PWM
// stream (frame = 2^PERIOD_LOG2 clocks).
//   clk        in   sole clock
//   rst        in   synchronous active-high reset
//   pwm_in     in   PWM line, asynchronous to clk
//   pcm_out    out  signed recovered sample
//   pcm_valid  out  one-cycle strobe, pcm_out is new
//   locked     out  frame alignment established
//   sync_err   out  one-cycle pulse per bad-frame event
// Build option: define PWM_TO_PCM_AVG_EN to output the mean of the current and
// previous decoded samples (first sample after lock passes through).
//
// state | meaning
// HUNT  | no alignment; waiting for a rising edge to anchor frame start
// TRACK | counting frame index k and high cycles hc, one sample per frame
module pwm_to_pcm
  import pwm_pcm_pkg::*;
#(
  parameter int PERIOD_LOG2 = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOSS_LIMIT  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pwm_in,
  output logic signed [PCM_W-1:0] pcm_out,
  output logic                    pcm_valid,
  output logic                    locked,
  output logic                    sync_err
);

  localparam int KW     = PERIOD_LOG2;
  localparam int HC_W   = PERIOD_LOG2 + 1;
  localparam int LOSS_W = $clog2(LOSS_LIMIT + 1);

  localparam logic [KW-1:0]     K_ONE    = KW'(1);
  localparam logic [KW-1:0]     K_LAST   = '1;
  localparam logic [HC_W-1:0]   HC_ONE   = HC_W'(1);
  localparam logic [LOSS_W-1:0] LOSS_ONE = LOSS_W'(1);

  logic s, rise;

  pwm_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .d_in (pwm_in),
    .s    (s),
    .rise (rise)
  );

  pwm_dec_state_t    state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [HC_W-1:0]   hc_q, hc_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              frame_bad_q, frame_bad_d;
  logic [PCM_W-1:0]  pcm_q, pcm_d;
  logic              valid_q, valid_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;

`ifdef PWM_TO_PCM_AVG_EN
  logic [PCM_W-1:0]  prev_q, prev_d;
  logic              prev_ok_q, prev_ok_d;
`endif

  logic [HC_W-1:0]   hc_sum;
  logic [PCM_W-1:0]  dec;
  logic              bad_evt;
  logic              loss_hit;

  // hc_sum includes the current cycle, so at k = P-1 it is the full frame count.
  assign hc_sum   = hc_q + HC_W'(s);
  assign dec      = decode_hc(17'(hc_sum), PERIOD_LOG2);
  assign loss_hit = (int'(loss_q) + 1) >= LOSS_LIMIT;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    hc_d        = hc_q;
    loss_d      = loss_q;
    frame_bad_d = frame_bad_q;
    pcm_d       = pcm_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    err_d       = 1'b0;
    bad_evt     = 1'b0;
`ifdef PWM_TO_PCM_AVG_EN
    prev_d      = prev_q;
    prev_ok_d   = prev_ok_q;
`endif

    unique case (state_q)
      HUNT: begin
`ifdef PWM_TO_PCM_AVG_EN
        prev_ok_d = 1'b0;
`endif
        // The rise cycle is k = 0 and already counts one high cycle.
        if (rise) begin
          state_d     = TRACK;
          k_d         = K_ONE;
          hc_d        = HC_ONE;
          frame_bad_d = 1'b0;
        end
      end

      TRACK: begin
        if (rise && (k_q != '0)) begin
          // Realign: drop the partial frame; this cycle becomes k = 0.
          err_d       = 1'b1;
          bad_evt     = 1'b1;
          k_d         = K_ONE;
          hc_d        = HC_ONE;
          frame_bad_d = 1'b0;
        end else begin
          k_d  = k_q + K_ONE;
          hc_d = hc_sum;
          if (k_q == '0) begin
            frame_bad_d = ~s;
            if (!s) begin
              err_d   = 1'b1;
              bad_evt = 1'b1;
            end
          end
          if (k_q == K_LAST) begin
            valid_d = 1'b1;
            hc_d    = '0;
`ifdef PWM_TO_PCM_AVG_EN
            pcm_d     = prev_ok_q ? avg_pcm(dec, prev_q) : dec;
            prev_d    = dec;
            prev_ok_d = 1'b1;
`else
            pcm_d = dec;
`endif
            if (!frame_bad_q) begin
              loss_d   = '0;
              locked_d = 1'b1;
            end
          end
        end

        // Loss counts at detection time so locked falls with the last sync_err.
        if (bad_evt) begin
          if (loss_hit) begin
            state_d  = HUNT;
            locked_d = 1'b0;
            loss_d   = '0;
            k_d      = '0;
            hc_d     = '0;
          end else begin
            loss_d = loss_q + LOSS_ONE;
          end
        end
      end

      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      k_q         <= '0;
      hc_q        <= '0;
      loss_q      <= '0;
      frame_bad_q <= 1'b0;
      pcm_q       <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
`ifdef PWM_TO_PCM_AVG_EN
      prev_q      <= '0;
      prev_ok_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      hc_q        <= hc_d;
      loss_q      <= loss_d;
      frame_bad_q <= frame_bad_d;
      pcm_q       <= pcm_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
`ifdef PWM_TO_PCM_AVG_EN
      prev_q      <= prev_d;
      prev_ok_q   <= prev_ok_d;
`endif
    end
  end

  assign pcm_out   = pcm_q;
  assign pcm_valid = valid_q;
  assign locked    = locked_q;
  assign sync_err  = err_q;

endmodule

// File: tb/tb_pwm_to_pcm.sv
// tb_pwm_to_pcm: builds a PWM trace up front (directed frames plus random
// frames and phase jumps), derives the expected outputs per cycle from a
// frame-level reference model, then replays the trace and compares every cycle.
// Honours PWM_TO_PCM_AVG_EN in the model when the design is built with it.
module tb_pwm_to_pcm;

  localparam int PL   = 8;
  localparam int P    = 1 << PL;
  localparam int SYNC = 2;
  localparam int LIM  = 3;
  localparam int LAT  = SYNC + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               pwm_in = 1'b0;
  logic signed [15:0] pcm_out;
  logic               pcm_valid;
  logic               locked;
  logic               sync_err;

  pwm_to_pcm #(
    .PERIOD_LOG2 (PL),
    .SYNC_STAGES (SYNC),
    .LOSS_LIMIT  (LIM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .pcm_out   (pcm_out),
    .pcm_valid (pcm_valid),
    .locked    (locked),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit pw_q[$];
  bit rs_q[$];
  int n_cyc;
  int seg_end;

  bit s_a[], rise_a[], rcyc[], ev_valid[], ev_err[];
  int ev_lock[], ev_pcm[];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      pw_q.push_back(v);
      rs_q.push_back(1'b0);
    end
  endtask

  task automatic push_frame(input int h);
    push(1'b1, h);
    push(1'b0, P - h);
  endtask

  function automatic int find_rise(input int from, input int to);
    for (int j = from; j <= to; j++)
      if (j >= 0 && j < n_cyc && rise_a[j]) return j;
    return -1;
  endfunction

  // Scale high count to full 16-bit range, clamp, then recentre around zero.
  function automatic int decode(input int hc);
    int v;
    v = hc * (65536 / P);
    if (v > 65535) v = 65535;
    return v - 32768;
  endfunction

  task automatic add_err(input int t);
    if (t < seg_end) ev_err[t] = 1'b1;
  endtask

  task automatic add_lock(input int t, input int v);
    if (t < seg_end) ev_lock[t] = v;
  endtask

  task automatic add_valid(input int t, input int v);
    if (t < seg_end) begin
      ev_valid[t] = 1'b1;
      ev_pcm[t]   = v;
    end
  endtask

  task automatic run_model();
    int  e, t, a, j, loss, hs, dec, outv, prev, lim_to;
    bit  hunt, bad_f, prev_ok;
    prev = 0;
    for (int b = 0; b < n_cyc; b++) begin
      if (!rcyc[b]) continue;
      if (b + 1 < n_cyc && rcyc[b + 1]) continue;
      e = n_cyc;
      for (int x = b + 1; x < n_cyc; x++)
        if (rcyc[x]) begin
          e = x;
          break;
        end
      seg_end = e;
      hunt = 1'b1; t = b; loss = 0; prev_ok = 1'b0; a = 0;
      while (1) begin
        if (hunt) begin
          j = find_rise(t, e - 2);
          if (j < 0) break;
          a = j; hunt = 1'b0; prev_ok = 1'b0;
        end
        if (a > e - 2) break;
        bad_f = !s_a[a];
        if (bad_f) begin
          add_err(a + 1);
          loss++;
          if (loss == LIM) begin
            add_lock(a + 1, 0); loss = 0; hunt = 1'b1; t = a + 1;
            continue;
          end
        end
        lim_to = (a + P - 1 < e - 2) ? a + P - 1 : e - 2;
        j = find_rise(a + 1, lim_to);
        if (j >= 0) begin
          add_err(j + 1);
          loss++;
          if (loss == LIM) begin
            add_lock(j + 1, 0); loss = 0; hunt = 1'b1; t = j + 1;
            continue;
          end
          a = j;
          continue;
        end
        if (a + P - 1 > e - 2) break;
        hs = 0;
        for (int q = a; q < a + P; q++) hs += int'(s_a[q]);
        dec = decode(hs);
`ifdef PWM_TO_PCM_AVG_EN
        outv    = prev_ok ? ((dec + prev) >>> 1) : dec;
        prev    = dec;
        prev_ok = 1'b1;
`else
        outv = dec;
`endif
        add_valid(a + P, outv);
        if (!bad_f) begin
          loss = 0;
          add_lock(a + P, 1);
        end
        a = a + P;
      end
    end
  endtask

  initial begin
    int r, h, lock_lvl, pcm_lvl;
    logic [15:0] got_pcm;

    // reset with the line low, then idle
    for (int i = 0; i < 8; i++) begin
      pw_q.push_back(1'b0);
      rs_q.push_back(1'b1);
    end
    push(1'b0, 20);
    // mid-scale lock
    for (int i = 0; i < 6; i++) push_frame(128);
    // values across the range, including full-high and single-high frames
    push_frame(147); push_frame(P); push_frame(P); push_frame(1);
    for (int i = 0; i < 8; i++) push_frame($urandom_range(1, P - 1));
    // phase jump: early rise at k = 100
    push_frame(128);
    push(1'b1, 60); push(1'b0, 40);
    for (int i = 0; i < 3; i++) push_frame(128);
    // loss of lock then relock
    push(1'b0, 4 * P + 20);
    for (int i = 0; i < 3; i++) push_frame(128);
    // reset mid-frame while locked
    push(1'b1, 50);
    pw_q.push_back(1'b1); rs_q.push_back(1'b1);
    push(1'b1, 147 - 51); push(1'b0, P - 147);
    for (int i = 0; i < 3; i++) push_frame(147);
    // random frames with occasional empty, full and phase-jumped frames
    for (int i = 0; i < 15; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) push_frame(0);
      else if (r == 1) push_frame(P);
      else if (r == 2) begin
        push(1'b1, $urandom_range(1, 50));
        push(1'b0, $urandom_range(20, 100));
        push_frame($urandom_range(1, P - 1));
      end else begin
        h = $urandom_range(1, P - 1);
        push_frame(h);
      end
    end
    push(1'b0, 2 * P);

    n_cyc = pw_q.size();
    s_a = new[n_cyc]; rise_a = new[n_cyc]; rcyc = new[n_cyc];
    ev_valid = new[n_cyc]; ev_err = new[n_cyc];
    ev_lock = new[n_cyc]; ev_pcm = new[n_cyc];
    for (int t = 0; t < n_cyc; t++) begin
      s_a[t]      = (t >= LAT) ? pw_q[t - LAT] : 1'b0;
      rise_a[t]   = (t >= 1) ? (s_a[t] & ~s_a[t - 1]) : 1'b0;
      rcyc[t]     = (t == 0) ? 1'b1 : rs_q[t - 1];
      ev_valid[t] = 1'b0;
      ev_err[t]   = 1'b0;
      ev_lock[t]  = -1;
      ev_pcm[t]   = 0;
    end
    run_model();

    lock_lvl = 0;
    pcm_lvl  = 0;
    for (int t = 0; t < n_cyc; t++) begin
      @(posedge clk);
      #1;
      pwm_in = pw_q[t];
      rst    = rs_q[t];
      if (rcyc[t]) begin
        lock_lvl = 0;
        pcm_lvl  = 0;
      end else begin
        if (ev_lock[t] >= 0) lock_lvl = ev_lock[t];
        if (ev_valid[t]) pcm_lvl = ev_pcm[t];
      end
      @(negedge clk);
      got_pcm = pcm_out;
      check_eq($sformatf("valid@%0d", t), 32'(pcm_valid), 32'(ev_valid[t]));
      check_eq($sformatf("sync_err@%0d", t), 32'(sync_err), 32'(ev_err[t]));
      check_eq($sformatf("locked@%0d", t), 32'(locked), 32'(lock_lvl));
      check_eq($sformatf("pcm@%0d", t), {16'h0, got_pcm}, 32'(pcm_lvl & 32'hFFFF));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
